// File: rtl/lane_pkg.sv
// Shared types and constants for the lane bit collector.
package lane_pkg;

    typedef enum logic {FILL = 1'b0, WAIT = 1'b1} lane_col_state_t;

    localparam int LANE_WIDTH = 4;
    localparam int LANE_SEL_W = $clog2(LANE_WIDTH);

    // Lane index width for a given lane count; never narrower than one bit.
    function automatic int sel_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_out_reg.sv
// Output word register with valid/ready hold; a new load wins over a dequeue.
module lane_out_reg
    import lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    // Load a completed word, otherwise drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= data_in;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lane_bit_collector.sv
// Serial-to-parallel lane collector: assembles one bit per lane into a word.
//
// state | meaning
// FILL  | accepting lane bits into the assembly word
// WAIT  | word complete, output register busy; input stalled
module lane_bit_collector
    import lane_pkg::*;
#(
    parameter int WIDTH = LANE_WIDTH,
    parameter int SEL_W = sel_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dup_err,
    output logic             range_err
);

    // Compare in SEL_W+1 bits so the bound is representable for any WIDTH.
    localparam logic [SEL_W:0] LANES = (SEL_W + 1)'(WIDTH);

    lane_col_state_t  state;
    lane_col_state_t  state_next;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] lane_hot;
    logic [WIDTH-1:0] word_merged;
    logic [WIDTH-1:0] mask_merged;
    logic [WIDTH-1:0] load_data;
    logic             xfer;
    logic             in_range;
    logic             out_free;
    logic             load;
    logic             dup_next;
    logic             range_next;

    assign din_ready   = (state == FILL) && rst_n;
    assign xfer        = din_valid && din_ready;
    assign in_range    = {1'b0, sel} < LANES;
    // An out-of-range index selects no lane at all.
    assign lane_hot    = in_range ? (WIDTH'(1) << sel) : '0;
    assign word_merged = din ? (word | lane_hot) : (word & ~lane_hot);
    assign mask_merged = mask | lane_hot;
    assign out_free    = !dout_valid || dout_ready;

    // Next-state, assembly update and output-load decision.
    always_comb begin
        state_next = state;
        word_next  = word;
        mask_next  = mask;
        load       = 1'b0;
        load_data  = word;
        dup_next   = 1'b0;
        range_next = 1'b0;
        if (flush) begin
            state_next = FILL;
            word_next  = '0;
            mask_next  = '0;
        end else begin
            case (state)
                FILL: begin
                    if (xfer) begin
                        if (!in_range) begin
                            range_next = 1'b1;
                        end else begin
                            dup_next  = |(mask & lane_hot);
                            word_next = word_merged;
                            mask_next = mask_merged;
                            if (&mask_merged) begin
                                if (out_free) begin
                                    load      = 1'b1;
                                    load_data = word_merged;
                                    word_next = '0;
                                    mask_next = '0;
                                end else begin
                                    state_next = WAIT;
                                end
                            end
                        end
                    end
                end
                WAIT: begin
                    if (out_free) begin
                        load       = 1'b1;
                        load_data  = word;
                        word_next  = '0;
                        mask_next  = '0;
                        state_next = FILL;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    // State, assembly registers and registered error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            word      <= '0;
            mask      <= '0;
            dup_err   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            mask      <= mask_next;
            dup_err   <= dup_next;
            range_err <= range_next;
        end
    end

    lane_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (load_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

endmodule

// File: tb/tb_lane_bit_collector.sv
// Self-checking bench: directed scenarios plus a randomized run against a lane-array model.
module tb_lane_bit_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    int         n_cmp = 0;
    int         n_err = 0;

    // WIDTH=4 instance
    logic       flush, din_valid, din, dout_ready;
    logic [1:0] sel;
    logic       din_ready, dout_valid, dup_err, range_err;
    logic [3:0] dout;

    // WIDTH=3 instance (exercises out-of-range lane indices)
    logic       flush3, din_valid3, din3, dout_ready3;
    logic [1:0] sel3;
    logic       din_ready3, dout_valid3, dup_err3, range_err3;
    logic [2:0] dout3;

    always #5 clk = ~clk;

    lane_bit_collector #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din_valid(din_valid),
        .din_ready(din_ready), .din(din), .sel(sel), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout(dout), .dup_err(dup_err), .range_err(range_err)
    );

    lane_bit_collector #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3), .din_valid(din_valid3),
        .din_ready(din_ready3), .din(din3), .sel(sel3), .dout_valid(dout_valid3),
        .dout_ready(dout_ready3), .dout(dout3), .dup_err(dup_err3), .range_err(range_err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic b, input logic [1:0] s);
        din_valid = 1'b1;
        din       = b;
        sel       = s;
        tick();
    endtask

    task automatic drain();
        din_valid  = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0; din_valid = 1'b0; din = 1'b0; sel = '0; dout_ready = 1'b0;
        flush3 = 1'b0; din_valid3 = 1'b0; din3 = 1'b0; sel3 = '0; dout_ready3 = 1'b1;
        tick();
        tick();
        n_cmp++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL reset_din_ready: got %b want 0", din_ready); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        n_cmp++; if (dout !== 4'b0000) begin n_err++; $display("FAIL reset_dout: got %b want 0000", dout); end
        n_cmp++; if ({dup_err, range_err} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b want 00", {dup_err, range_err}); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", din_ready); end
    endtask

    task automatic test_in_order();
        drain();
        put(1'b1, 2'd0);
        put(1'b0, 2'd1);
        put(1'b1, 2'd2);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL inorder_early_valid: got %b want 0", dout_valid); end
        put(1'b1, 2'd3);
        din_valid = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL inorder_valid: got %b want 1", dout_valid); end
        n_cmp++; if (dout !== 4'b1101) begin n_err++; $display("FAIL inorder_dout: got %b want 1101", dout); end
        n_cmp++; if ({dup_err, range_err} !== 2'b00) begin n_err++; $display("FAIL inorder_errs: got %b want 00", {dup_err, range_err}); end
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL inorder_one_cycle: got %b want 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        int         off;
        drain();
        for (int k = 0; k < 4; k++) begin
            w   = 4'($urandom);
            off = int'($urandom_range(3));
            for (int i = 0; i < 4; i++) begin
                put(w[(i + off) % 4], 2'((i + off) % 4));
                if (i < 3) begin
                    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap_valid: word %0d lane step %0d got %b want 0", k, i, dout_valid); end
                end else begin
                    n_cmp++; if (dout_valid !== 1'b1 || dout !== w) begin n_err++; $display("FAIL b2b_word: word %0d got valid %b dout %b want valid 1 dout %b", k, dout_valid, dout, w); end
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        drain();
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(i[0], 2'(i));
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'hA) begin n_err++; $display("FAIL bp_first: got valid %b dout %h want valid 1 dout a", dout_valid, dout); end
        for (int i = 0; i < 4; i++) put(~i[0], 2'(i));
        din_valid = 1'b0;
        n_cmp++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_wait_ready: got %b want 0", din_ready); end
        tick();
        tick();
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'hA) begin n_err++; $display("FAIL bp_hold: got valid %b dout %h want valid 1 dout a", dout_valid, dout); end
        n_cmp++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_wait: got %b want 0", din_ready); end
        dout_ready = 1'b1;
        tick();
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'h5) begin n_err++; $display("FAIL bp_second: got valid %b dout %h want valid 1 dout 5", dout_valid, dout); end
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", din_ready); end
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", dout_valid); end
    endtask

    task automatic test_dup();
        drain();
        put(1'b1, 2'd2);
        n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL dup_first_write: got %b want 0", dup_err); end
        put(1'b0, 2'd2);
        n_cmp++; if (dup_err !== 1'b1) begin n_err++; $display("FAIL dup_pulse: got %b want 1", dup_err); end
        put(1'b1, 2'd0);
        n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL dup_one_cycle: got %b want 0", dup_err); end
        put(1'b1, 2'd1);
        put(1'b1, 2'd3);
        din_valid = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'b1011) begin n_err++; $display("FAIL dup_word: got valid %b dout %b want valid 1 dout 1011", dout_valid, dout); end
    endtask

    task automatic test_range();
        din_valid3 = 1'b1; din3 = 1'b1; sel3 = 2'd3;
        tick();
        n_cmp++; if (range_err3 !== 1'b1) begin n_err++; $display("FAIL range_pulse: got %b want 1", range_err3); end
        n_cmp++; if (dout_valid3 !== 1'b0) begin n_err++; $display("FAIL range_no_word: got %b want 0", dout_valid3); end
        sel3 = 2'd0; din3 = 1'b1;
        tick();
        n_cmp++; if (range_err3 !== 1'b0) begin n_err++; $display("FAIL range_one_cycle: got %b want 0", range_err3); end
        sel3 = 2'd1; din3 = 1'b1;
        tick();
        n_cmp++; if (dout_valid3 !== 1'b0) begin n_err++; $display("FAIL range_mask_early: got %b want 0", dout_valid3); end
        sel3 = 2'd2; din3 = 1'b0;
        tick();
        din_valid3 = 1'b0;
        n_cmp++; if (dout_valid3 !== 1'b1 || dout3 !== 3'b011) begin n_err++; $display("FAIL range_word: got valid %b dout %b want valid 1 dout 011", dout_valid3, dout3); end
        n_cmp++; if ({dup_err3, range_err3} !== 2'b00) begin n_err++; $display("FAIL range_errs_after: got %b want 00", {dup_err3, range_err3}); end
    endtask

    task automatic test_flush();
        drain();
        put(1'b1, 2'd0);
        put(1'b1, 2'd1);
        flush = 1'b1;
        put(1'b1, 2'd2);
        flush = 1'b0;
        n_cmp++; if (dout_valid !== 1'b0 || dup_err !== 1'b0) begin n_err++; $display("FAIL flush_quiet: got valid %b dup %b want 0 0", dout_valid, dup_err); end
        put(1'b0, 2'd0);
        n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL flush_mask_cleared: got dup %b want 0", dup_err); end
        put(1'b0, 2'd1);
        put(1'b0, 2'd2);
        n_cmp++; if (dout_valid !== 1'b0 || dup_err !== 1'b0) begin n_err++; $display("FAIL flush_ignored_input: got valid %b dup %b want 0 0", dout_valid, dup_err); end
        put(1'b0, 2'd3);
        din_valid = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'b0000) begin n_err++; $display("FAIL flush_word: got valid %b dout %b want valid 1 dout 0000", dout_valid, dout); end
    endtask

    task automatic test_reset_mid();
        drain();
        put(1'b1, 2'd0);
        put(1'b1, 2'd1);
        put(1'b1, 2'd2);
        din_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_cmp++; if ({din_ready, dout_valid, dout, dup_err, range_err} !== 8'h00) begin n_err++; $display("FAIL rstmid_outputs: got %b want 00000000", {din_ready, dout_valid, dout, dup_err, range_err}); end
        rst_n = 1'b1;
        put(1'b0, 2'd3);
        put(1'b1, 2'd2);
        put(1'b1, 2'd1);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_partial_dropped: got %b want 0", dout_valid); end
        put(1'b0, 2'd0);
        din_valid = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'b0110) begin n_err++; $display("FAIL rstmid_word: got valid %b dout %b want valid 1 dout 0110", dout_valid, dout); end
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_single_word: got %b want 0", dout_valid); end
    endtask

    // Model: per-lane value/filled arrays, a pending-word flag and the output slot.
    task automatic test_random();
        bit         m_lane [4];
        bit         m_fill [4];
        bit         m_wait, m_dv, m_dup, free, ld, exp_ready;
        logic [3:0] m_dout, ldv;
        int         filled;
        din_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin m_lane[i] = 1'b0; m_fill[i] = 1'b0; end
        m_wait = 1'b0; m_dv = 1'b0; m_dout = '0;
        for (int c = 0; c < 2000; c++) begin
            din_valid  = ($urandom_range(3) != 0);
            din        = 1'($urandom_range(1));
            sel        = 2'($urandom_range(3));
            dout_ready = 1'($urandom_range(1));
            flush      = ($urandom_range(15) == 0);
            exp_ready  = !m_wait;
            #1;
            n_cmp++; if (din_ready !== exp_ready) begin n_err++; $display("FAIL rand_din_ready: cycle %0d got %b want %b", c, din_ready, exp_ready); end
            free  = !m_dv || dout_ready;
            ld    = 1'b0;
            ldv   = '0;
            m_dup = 1'b0;
            if (flush) begin
                for (int i = 0; i < 4; i++) m_fill[i] = 1'b0;
                m_wait = 1'b0;
            end else if (m_wait) begin
                if (free) begin
                    ld = 1'b1;
                    for (int i = 0; i < 4; i++) begin ldv[i] = m_lane[i]; m_fill[i] = 1'b0; end
                    m_wait = 1'b0;
                end
            end else if (din_valid) begin
                m_dup       = m_fill[sel];
                m_lane[sel] = din;
                m_fill[sel] = 1'b1;
                filled = 0;
                for (int i = 0; i < 4; i++) filled += int'(m_fill[i]);
                if (filled == 4) begin
                    if (free) begin
                        ld = 1'b1;
                        for (int i = 0; i < 4; i++) begin ldv[i] = m_lane[i]; m_fill[i] = 1'b0; end
                    end else begin
                        m_wait = 1'b1;
                    end
                end
            end
            if (ld) begin
                m_dv   = 1'b1;
                m_dout = ldv;
            end else if (m_dv && dout_ready) begin
                m_dv = 1'b0;
            end
            tick();
            n_cmp++; if (dout_valid !== m_dv) begin n_err++; $display("FAIL rand_dout_valid: cycle %0d got %b want %b", c, dout_valid, m_dv); end
            if (m_dv) begin
                n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL rand_dout: cycle %0d got %b want %b", c, dout, m_dout); end
            end
            n_cmp++; if (dup_err !== m_dup) begin n_err++; $display("FAIL rand_dup_err: cycle %0d got %b want %b", c, dup_err, m_dup); end
            n_cmp++; if (range_err !== 1'b0) begin n_err++; $display("FAIL rand_range_err: cycle %0d got %b want 0", c, range_err); end
        end
        din_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_back_to_back();
        test_backpressure();
        test_dup();
        test_range();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lane_bit_collector.md
# lane_bit_collector

Serial-to-parallel lane collector: accepts one data bit per handshake, tagged with a lane index `sel`, and writes it into bit `sel` of an assembly word. When every lane bit has been written, it hands the completed `WIDTH`-bit word to a registered output stage. It sits on the write side of the lane-select datapath, rebuilding the word that the bit-select mux later reads one lane at a time. It detects duplicate lane writes and out-of-range lane indices.

## Interface
- `WIDTH`, 4, number of lanes and width of the output word (≥2).
- `SEL_W`, `$clog2(WIDTH)`, width of the lane index.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard the partial assembly word.
- `din_valid`  in  1  input bit present.
- `din_ready`  out  1  collector can accept a bit.
- `din`  in  1  data bit.
- `sel`  in  SEL_W  target lane index.
- `dout_valid`  out  1  completed word present.
- `dout_ready`  in  1  consumer accepts the word.
- `dout`  out  WIDTH  completed word, bit i = last bit written to lane i.
- `dup_err`  out  1  one-cycle pulse: a write hit an already-filled lane.
- `range_err`  out  1  one-cycle pulse: `sel >= WIDTH`; the bit is dropped.

## Operation
- State is held in an assembly register `word[WIDTH-1:0]`, a fill mask `mask[WIDTH-1:0]`, an output register (`dout`/`dout_valid`), and a two-state FSM: FILL and WAIT.
- `din_ready = (state == FILL) && rst_n`.
- Input transfer: `din_valid && din_ready`.
- `out_free = !dout_valid || dout_ready`.

**FILL, on an input transfer with `sel < WIDTH`**
- `word[sel] <= din`; `mask[sel] <= 1`.
- If `mask[sel]` was already 1: the bit overwrites the old value and `dup_err` pulses on the next cycle.

**FILL, on an input transfer with `sel >= WIDTH`** (possible only when WIDTH is not a power of 2)
- Word and mask are unchanged; `range_err` pulses.

**Completion** (the mask including the current write becomes all ones)
- If `out_free`: `dout <= word` with the new bit merged, `dout_valid <= 1`, mask cleared, stay in FILL.
- Otherwise: go to WAIT with the word and mask held.

**WAIT**
- `din_ready = 0`.
- On `out_free`: transfer the word to `dout`, set `dout_valid`, clear the mask, go to FILL.

**Output**
- `dout_valid` clears on `dout_valid && dout_ready` unless a new word loads in the same cycle. A new load takes priority, giving back-to-back words.
- `dout` holds stable while `dout_valid && !dout_ready`.

**Flush**
- Clears `word` and `mask` and forces FILL.
- No error pulse.
- An input transfer in the same cycle is ignored.
- A word already in the output register is kept.
- Flush in WAIT discards the held word.

## Timing
- Reset (while `rst_n` is low at a rising edge): state = FILL, `word = 0`, `mask = 0`, `dout = 0`, `dout_valid = 0`, `dup_err = 0`, `range_err = 0`. `din_ready` is 0 while `rst_n` is low.
- Reset mid-word or mid-WAIT drops all partial and pending data.
- Latency: the last lane bit accepted at edge N gives `dout_valid = 1` after edge N, provided `out_free` holds at N.
- Throughput: one word per WIDTH cycles when the consumer is always ready; no bubbles.
- `dup_err` and `range_err` are registered and high for exactly one cycle per offending transfer.
- Priority within a cycle: reset > flush > input transfer.
- The output dequeue is independent of flush.

## Structure
- Shared package `lane_pkg`:
  - `typedef enum logic {FILL, WAIT} lane_col_state_t;`
  - the default lane count constant `LANE_WIDTH = 4`.
  - the helper constant for `SEL_W` derivation.
- The output register with valid/ready hold behaviour is a natural sub-module: `lane_out_reg` (parameter `WIDTH`; `load`/`data_in`/`dout`/`dout_valid`/`dout_ready`).
- The FSM and the mask logic stay in the top module.

## Test plan
- **In-order fill:** WIDTH=4, bits 1,0,1,1 to sel 0,1,2,3, `dout_ready=1` → `dout=4'b1101`, `dout_valid` high for one cycle immediately after the 4th accept; no errors.
- **Back-pressure:** hold `dout_ready=0`, fill two words (`4'hA`, then `4'h5`) → first word held stable; after 4 more accepts the FSM is in WAIT and `din_ready=0`. Raise `dout_ready` → `4'hA` out, then `4'h5`, then `din_ready=1`.
- **Duplicate lane:** write sel 2 = 1, then sel 2 = 0, then sel 0/1/3 = 1 → one `dup_err` pulse; `dout=4'b1011`.
- **Range error:** WIDTH=3 (SEL_W=2), sel=3 → `range_err` pulse, mask unchanged; lanes 0–2 = 1,1,0 → `dout=3'b011`.
- **Flush:** write sel 0 and 1, assert `flush` together with a `din_valid` to sel 2, then write all four lanes = 0 → `dout=4'b0000`; no output before the flush, no error.
- **Reset mid-word:** 3 lanes written, `rst_n` low one cycle → all outputs 0; the next 4 writes produce exactly one word.
